// File: rtl/funnel_ctrl_1_3_pkg.sv
// Shared definitions for the funnel / defunnel lane-packing controls.
// Mode encodings and the mode-to-step decode live here so both sides agree.
package funnel_ctrl_1_3_pkg;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_X1   = 2'd1;
  localparam logic [1:0] MODE_X2   = 2'd2;

  // Lanes consumed per beat. Bit0 wins, so mode 3 acts as single-lane.
  function automatic logic [1:0] step_of(input logic [1:0] mode);
    if ((mode & MODE_X1) != MODE_IDLE)
      return 2'd1;
    else if ((mode & MODE_X2) != MODE_IDLE)
      return 2'd2;
    else
      return 2'd0;
  endfunction

endpackage

// File: rtl/funnel_ctrl_1_3_lane_ptr.sv
// Lane pointer for the funnel: advances by the beat step, flags the
// wrap that ends a word, and decodes the lane enables for the narrow mux.
module funnel_lane_ptr #(
  parameter  int LANES = 4,
  localparam int PW    = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       step,
  input  logic             beat,
  output logic [PW-1:0]    ptr,
  output logic             wrap,
  output logic [LANES-1:0] enable
);

  logic [PW:0]        sum;
  logic [LANES-1:0]   mask;

  // One spare bit so ptr + step == LANES is visible before truncation.
  assign sum  = {1'b0, ptr} + (PW+1)'(step);
  assign wrap = (sum == (PW+1)'(LANES));

  always_comb begin
    mask    = '0;
    mask[0] = (step != 2'd0);
    mask[1] = (step == 2'd2);
    enable  = beat ? (mask << ptr) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (beat)
      ptr <= sum[PW-1:0];
  end

endmodule

// File: rtl/funnel_ctrl_1_3.sv
// Transmit-side funnel control: accepts a wide word, then emits it as
// one- or two-lane beats on i_0/i_1. Drives register load and lane select only.
module funnel_ctrl_1_3
  import funnel_ctrl_1_3_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int PW    = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t_0_req,
  output logic             t_0_ack,
  input  logic             t_cfg_req,
  output logic             t_cfg_ack,
  input  logic [1:0]       cfg_mode,
  output logic             i_0_req,
  input  logic             i_0_ack,
  output logic             i_1_req,
  input  logic             i_1_ack,
  output logic             load,
  output logic [PW-1:0]    sel,
  output logic [LANES-1:0] enable
);

  logic [1:0] mode_q;
  logic [1:0] step;
  logic       full;
  logic       beat;
  logic       wrap;
  logic       last;

  assign step    = step_of(mode_q);
  assign i_0_req = full & (step != 2'd0);
  assign i_1_req = full & (step == 2'd2);

  // Two-lane beats advance only when both downstream ports accept together.
  always_comb begin
    case (step)
      2'd1:    beat = i_0_req & i_0_ack;
      2'd2:    beat = i_0_req & i_1_req & i_0_ack & i_1_ack;
      default: beat = 1'b0;
    endcase
  end

  assign last = beat & wrap;

  // Config beats a pending word while empty, so no word straddles two modes.
  assign t_0_ack   = (step != 2'd0) & (~full | last) & ~t_cfg_req;
  assign load      = t_0_req & t_0_ack;
  assign t_cfg_ack = ~full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_IDLE;
      full   <= 1'b0;
    end else begin
      if (t_cfg_req & t_cfg_ack)
        mode_q <= cfg_mode;
      if (load)
        full <= 1'b1;
      else if (last)
        full <= 1'b0;
    end
  end

  funnel_lane_ptr #(
    .LANES (LANES)
  ) u_lane_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step),
    .beat    (beat),
    .ptr     (sel),
    .wrap    (wrap),
    .enable  (enable)
  );

endmodule

// File: tb/tb_funnel_ctrl_1_3.sv
// Bench for funnel_ctrl_1_3: table vectors, directed corner sequences and
// random traffic against a lane-position reference model.
module tb_funnel_ctrl_1_3;

  localparam int LANES = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       t_0_req, t_cfg_req, i_0_ack, i_1_ack;
  logic [1:0] cfg_mode;
  logic       t_0_ack, t_cfg_ack, i_0_req, i_1_req, load;
  logic [1:0] sel;
  logic [3:0] enable;

  always #5 clk = ~clk;

  funnel_ctrl_1_3 #(.LANES(LANES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .t_0_req   (t_0_req),
    .t_0_ack   (t_0_ack),
    .t_cfg_req (t_cfg_req),
    .t_cfg_ack (t_cfg_ack),
    .cfg_mode  (cfg_mode),
    .i_0_req   (i_0_req),
    .i_0_ack   (i_0_ack),
    .i_1_req   (i_1_req),
    .i_1_ack   (i_1_ack),
    .load      (load),
    .sel       (sel),
    .enable    (enable)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode, whether a word is held, and next lane to send.
  int m_mode, m_pos, n_mode, n_pos;
  bit m_full, n_full;
  int e_t0ack, e_cfgack, e_i0, e_i1, e_load, e_sel, e_en;

  typedef struct {
    bit       tq, cq;
    bit [1:0] cm;
    bit       a0, a1;
    bit       et, ec, e0, e1, el;
    bit [1:0] es;
    bit [3:0] ee;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t v(bit tq, bit cq, bit [1:0] cm, bit a0, bit a1,
                             bit et, bit ec, bit e0, bit e1, bit el,
                             bit [1:0] es, bit [3:0] ee);
    vec_t r;
    r.tq = tq; r.cq = cq; r.cm = cm; r.a0 = a0; r.a1 = a1;
    r.et = et; r.ec = ec; r.e0 = e0; r.e1 = e1; r.el = el;
    r.es = es; r.ee = ee;
    return r;
  endfunction

  function automatic int lanes_per_beat(int md);
    case (md)
      1, 3:    return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_eval(input bit tq, cq, input bit [1:0] cm, input bit a0, a1);
    int  st;
    bit  beat, last;
    st       = lanes_per_beat(m_mode);
    e_i0     = int'(m_full && st > 0);
    e_i1     = int'(m_full && st == 2);
    beat     = (st == 1) ? (e_i0 != 0 && a0) :
               (st == 2) ? (e_i0 != 0 && a0 && a1) : 1'b0;
    last     = beat && (m_pos + st == LANES);
    e_t0ack  = int'(st > 0 && (!m_full || last) && !cq);
    e_load   = int'(tq && e_t0ack != 0);
    e_cfgack = int'(!m_full);
    e_sel    = m_pos;
    e_en     = 0;
    if (beat)
      for (int k = 0; k < st; k++) e_en += (1 << (m_pos + k));
    n_mode = (cq && !m_full) ? int'(cm) : m_mode;
    n_pos  = beat ? (m_pos + st) % LANES : m_pos;
    n_full = (e_load != 0) ? 1'b1 : (last ? 1'b0 : m_full);
  endtask

  task automatic drive_cycle(input bit tq, cq, input bit [1:0] cm, input bit a0, a1);
    @(negedge clk);
    t_0_req = tq; t_cfg_req = cq; cfg_mode = cm; i_0_ack = a0; i_1_ack = a1;
    #2;
    model_eval(tq, cq, cm, a0, a1);
  endtask

  task automatic commit();
    @(posedge clk);
    m_mode = n_mode; m_pos = n_pos; m_full = n_full;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_t0ack"},  int'(t_0_ack),   e_t0ack);
    chk({tag, "_cfgack"}, int'(t_cfg_ack), e_cfgack);
    chk({tag, "_i0req"},  int'(i_0_req),   e_i0);
    chk({tag, "_i1req"},  int'(i_1_req),   e_i1);
    chk({tag, "_load"},   int'(load),      e_load);
    chk({tag, "_sel"},    int'(sel),       e_sel);
    chk({tag, "_enable"}, int'(enable),    e_en);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_t0ack"},  int'(t_0_ack),   0);
    chk({tag, "_cfgack"}, int'(t_cfg_ack), 1);
    chk({tag, "_i0req"},  int'(i_0_req),   0);
    chk({tag, "_i1req"},  int'(i_1_req),   0);
    chk({tag, "_load"},   int'(load),      0);
    chk({tag, "_sel"},    int'(sel),       0);
    chk({tag, "_enable"}, int'(enable),    0);
  endtask

  task automatic run(input bit tq, cq, input bit [1:0] cm, input bit a0, a1, input string tag);
    drive_cycle(tq, cq, cm, a0, a1);
    check_model(tag);
    commit();
  endtask

  initial begin
    reset_n = 1'b0;
    t_0_req = 0; t_cfg_req = 0; cfg_mode = 0; i_0_ack = 0; i_1_ack = 0;
    m_mode = 0; m_pos = 0; m_full = 0;

    // Scenario 1 (mode 1) then scenario 2 (mode 2, back-to-back words).
    vt[0]  = v(0,1,1,0,0, 0,1,0,0,0, 0,4'h0);
    vt[1]  = v(1,0,0,1,0, 1,1,0,0,1, 0,4'h0);
    vt[2]  = v(0,0,0,1,0, 0,0,1,0,0, 0,4'h1);
    vt[3]  = v(0,0,0,1,0, 0,0,1,0,0, 1,4'h2);
    vt[4]  = v(0,0,0,1,0, 0,0,1,0,0, 2,4'h4);
    vt[5]  = v(0,0,0,1,0, 1,0,1,0,0, 3,4'h8);
    vt[6]  = v(0,1,2,0,0, 0,1,0,0,0, 0,4'h0);
    vt[7]  = v(1,0,0,1,1, 1,1,0,0,1, 0,4'h0);
    vt[8]  = v(1,0,0,1,1, 0,0,1,1,0, 0,4'h3);
    vt[9]  = v(1,0,0,1,1, 1,0,1,1,1, 2,4'hC);
    vt[10] = v(0,0,0,1,1, 0,0,1,1,0, 0,4'h3);
    vt[11] = v(0,0,0,1,1, 1,0,1,1,0, 2,4'hC);
    vt[12] = v(0,0,0,0,0, 1,1,0,0,0, 0,4'h0);

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    check_reset_vals("rst_rel");

    for (int i = 0; i < 13; i++) begin
      drive_cycle(vt[i].tq, vt[i].cq, vt[i].cm, vt[i].a0, vt[i].a1);
      chk($sformatf("vec%0d_t0ack", i),  int'(t_0_ack),   int'(vt[i].et));
      chk($sformatf("vec%0d_cfgack", i), int'(t_cfg_ack), int'(vt[i].ec));
      chk($sformatf("vec%0d_i0req", i),  int'(i_0_req),   int'(vt[i].e0));
      chk($sformatf("vec%0d_i1req", i),  int'(i_1_req),   int'(vt[i].e1));
      chk($sformatf("vec%0d_load", i),   int'(load),      int'(vt[i].el));
      chk($sformatf("vec%0d_sel", i),    int'(sel),       int'(vt[i].es));
      chk($sformatf("vec%0d_enable", i), int'(enable),    int'(vt[i].ee));
      commit();
    end

    // Mode 2 with only one downstream ack: no progress until both ack.
    run(1, 0, 0, 1, 0, "s3_load");
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 1, 0);
      check_model("s3_stall");
      chk("s3_stall_sel", int'(sel), 0);
      chk("s3_stall_en",  int'(enable), 0);
      chk("s3_stall_i1",  int'(i_1_req), 1);
      commit();
    end
    drive_cycle(0, 0, 0, 1, 1);
    check_model("s3_go");
    chk("s3_go_en", int'(enable), 3);
    commit();
    run(0, 0, 0, 1, 1, "s3_last");
    run(0, 0, 0, 0, 0, "s3_idle");

    // Mode 0 never accepts a word; mode 3 drains like mode 1.
    run(0, 1, 0, 0, 0, "s5_cfg0");
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 0, 0, 1, 1);
      check_model("s5_m0");
      chk("s5_m0_t0ack", int'(t_0_ack), 0);
      commit();
    end
    run(0, 1, 3, 0, 0, "s5_cfg3");
    run(1, 0, 0, 1, 0, "s5_load");
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 0, 1, 0);
      check_model("s5_m3");
      chk("s5_m3_en", int'(enable), 1 << i);
      commit();
    end

    // Config blocked while a word is held; cfg beats t_0 when empty.
    run(1, 0, 0, 0, 0, "s4_load");
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, 3, 1, 0);
      check_model("s4_busy");
      chk("s4_busy_cfgack", int'(t_cfg_ack), 0);
      commit();
    end
    drive_cycle(1, 1, 1, 0, 0);
    check_model("s4_both");
    chk("s4_both_load",   int'(load), 0);
    chk("s4_both_cfgack", int'(t_cfg_ack), 1);
    commit();

    // Reset mid-word after two beats.
    run(1, 0, 0, 0, 0, "s6_load");
    run(0, 0, 0, 1, 0, "s6_b0");
    run(0, 0, 0, 1, 0, "s6_b1");
    @(negedge clk);
    i_0_ack = 1; t_0_req = 0; t_cfg_req = 0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("s6_rst");
    m_mode = 0; m_pos = 0; m_full = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 1, 1);
      check_model("s6_after");
      chk("s6_after_i0", int'(i_0_req), 0);
      commit();
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      run(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/funnel_ctrl_1_3.md
Name: funnel_ctrl_1_3

Overview:
- Control for the funnel, the transmit-side counterpart of the lane-packing defunnel.
- Accepts one wide word of LANES lanes on target t_0 and parcels it out over initiator ports i_0 (and i_1) as narrow beats: one lane per beat (mode 1) or two lanes per beat (mode 2).
- Drives the load enable for the wide data register and the lane select/enable for the downstream narrow mux. Holds no data itself.
- Mode is configured through the t_cfg handshake.

Parameters:
- LANES, 4, lanes in the wide word. Power of two, >= 2.
- PW, $clog2(LANES), lane pointer width (derived; do not override).

Ports:
- clk  input  1  clock
- reset_n  input  1  reset; asynchronous, active-low
- t_0_req  input  1  wide word offered
- t_0_ack  output  1  wide word accepted (transfer = req & ack)
- t_cfg_req  input  1  config offered
- t_cfg_ack  output  1  config accepted
- cfg_mode  input  2  mode value, sampled on the cfg transfer
- i_0_req  output  1  narrow beat valid, lane sel
- i_0_ack  input  1  downstream 0 accepts
- i_1_req  output  1  narrow beat valid, lane sel+1 (mode 2 only)
- i_1_ack  input  1  downstream 1 accepts
- load  output  1  wide data register enable (= t_0 transfer)
- sel  output  PW  current lane pointer
- enable  output  LANES  one-hot/two-hot of the lanes emitted this cycle

Behaviour:
- State registers:
  - mode_q[1:0], reset 0.
  - full, reset 0.
  - ptr[PW-1:0], reset 0.
- Step decode from mode_q (bit0 has priority, matching the defunnel reduct rule):
  - step = 1 if mode_q[0].
  - step = 2 if mode_q[1] and not mode_q[0].
  - Otherwise step = 0, which is idle.
- Output requests:
  - i_0_req = full & (step != 0).
  - i_1_req = full & (step == 2).
  - Requests never depend on acks.
- beat:
  - step 1: i_0_req & i_0_ack.
  - step 2: i_0_req & i_1_req & i_0_ack & i_1_ack. Both are joint; a single ack makes no progress.
- last = beat & (ptr + step wraps to 0, i.e. ptr == LANES - step).
- On beat: ptr <= ptr + step, modulo LANES. On last, ptr returns to 0.
- Acks:
  - t_0_ack = (step != 0) & (~full | last) & ~t_cfg_req.
  - load = t_0_req & t_0_ack.
- full update:
  - set on load;
  - cleared on last without load;
  - held at 1 on last with load (back-to-back words, zero bubble).
- Config:
  - t_cfg_ack = ~full.
  - On t_cfg_req & t_cfg_ack, mode_q <= cfg_mode, effective next cycle.
  - Config has priority over t_0 when empty, so a word is never split across modes.
- enable:
  - step 1: beat ? (1 << ptr) : 0.
  - step 2: beat ? (3 << ptr) : 0.
  - Odd ptr never occurs in mode 2.
- Latency: first beat request the cycle after load. A full word drains in LANES/step cycles under continuous acks.
- Mode 3 behaves as mode 1. Mode 0 accepts no words (t_0_ack = 0) and emits nothing.
- Backpressure: while acks are low, ptr and full hold and requests stay high.
- Reset mid-word: the partial word is discarded and all state returns to reset values.
- Reset values of outputs:
  - t_0_ack = 0, because mode_q = 0.
  - t_cfg_ack = 1.
  - i_0_req = i_1_req = 0, load = 0, sel = 0, enable = 0.

Decomposition:
- Shared package holds:
  - MODE_IDLE = 2'd0, MODE_X1 = 2'd1, MODE_X2 = 2'd2;
  - the step decode function, which the defunnel control also uses.
- A sub-module is natural: funnel_lane_ptr (ptr register, step add, wrap/last detect, enable decode).
- The top keeps the full flag, mode_q and the handshakes.

Test Plan:
1. Reset, then cfg_mode = 1, one t_0 word, i_0_ack held 1 -> load pulse. Over the next 4 cycles sel = 0,1,2,3 and enable = 1,2,4,8. i_1_req stays 0. full drops after the 4th beat.
2. cfg_mode = 2, i_0_ack = i_1_ack = 1 -> two beats: enable = 4'b0011 then 4'b1100. On the second beat t_0_ack = 1 and a waiting word loads, with no idle cycle.
3. Mode 2, i_0_ack = 1 and i_1_ack = 0 for 3 cycles -> no beat and ptr stays 0. When i_1_ack rises, the beat completes.
4. t_cfg_req while full -> t_cfg_ack = 0 until the last beat. t_cfg_req and t_0_req together while empty -> only cfg is accepted.
5. cfg_mode = 0 with t_0_req held -> t_0_ack = 0 indefinitely. cfg_mode = 3 -> behaves as scenario 1.
6. Assert reset_n low after 2 beats of a mode-1 word -> all outputs return to reset values immediately, and no further beats are emitted after release.
